// File: rtl/pulse_period_monitor.sv
// pulse_period_monitor: per-channel rising-edge period measurement with tolerance-based lock tracking and saturating lock-loss counters
module pulse_period_monitor #(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 2,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [NUM_CH-1:0]             pulse_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   expected_i,
  input  logic [NUM_CH-1:0]             clear_i,
  output logic [NUM_CH*CNT_WIDTH-1:0]   period_o,
  output logic [NUM_CH-1:0]             period_vld_o,
  output logic [NUM_CH-1:0]             locked_o,
  output logic [NUM_CH*ERR_WIDTH-1:0]   err_cnt_o
);
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, LOST} state_t;
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH:0]   W_TOL = (CNT_WIDTH+1)'(TOL);
  localparam logic [CNT_WIDTH:0]   W_ONE = (CNT_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0] E_ONE = ERR_WIDTH'(1);
  localparam logic [MW-1:0]        M_ONE = MW'(1);
  localparam logic [MW-1:0]        M_LC  = MW'(LOCK_COUNT);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_WIDTH-1:0] w_e, w_p, r_cnt, r_per;
    logic [CNT_WIDTH:0]   w_hi;
    logic [ERR_WIDTH-1:0] r_err;
    logic [MW-1:0]        r_mc, w_mc_nxt, w_mc_inc;
    state_t               r_st, w_st_nxt;
    logic                 r_prev, r_vld, w_edge, w_en, w_sat, w_match, w_tmo, w_loss;
    assign w_e      = expected_i[c*CNT_WIDTH +: CNT_WIDTH];
    assign w_edge   = pulse_i[c] & ~r_prev;
    assign w_en     = |w_e;
    assign w_sat    = &r_cnt;
    assign w_p      = w_sat ? r_cnt : r_cnt + C_ONE;
    assign w_hi     = {1'b0, w_e} + W_TOL;
    assign w_match  = ({1'b0, w_p} + W_TOL >= {1'b0, w_e}) && ({1'b0, w_p} <= w_hi);
    // cnt passes E+TOL+1 exactly once per silent stretch, so this fires once
    assign w_tmo    = !w_edge && ({1'b0, r_cnt} == w_hi + W_ONE);
    assign w_mc_inc = r_mc + M_ONE;
    always_comb begin
      w_st_nxt = r_st;
      w_mc_nxt = r_mc;
      w_loss   = 1'b0;
      if (!w_en) begin
        w_st_nxt = IDLE;
        w_mc_nxt = '0;
      end else begin
        case (r_st)
          IDLE: if (w_edge) begin
            w_st_nxt = ACQ;
            w_mc_nxt = '0;
          end
          ACQ: if (w_edge && w_match) begin
            w_mc_nxt = w_mc_inc;
            w_st_nxt = (w_mc_inc == M_LC) ? LOCKED : ACQ;
          end else if (w_edge || w_tmo) begin
            w_mc_nxt = '0;
          end
          LOCKED: if ((w_edge && !w_match) || w_tmo) begin
            w_st_nxt = LOST;
            w_loss   = 1'b1;
          end
          LOST: if (w_edge && w_match) begin
            w_mc_nxt = M_ONE;
            w_st_nxt = (LOCK_COUNT == 1) ? LOCKED : ACQ;
          end
          default: w_st_nxt = IDLE;
        endcase
      end
    end
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        r_st <= IDLE;
        r_mc <= '0;
      end else begin
        r_st <= w_st_nxt;
        r_mc <= w_mc_nxt;
      end
    end
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        r_prev <= 1'b1;
        r_cnt  <= '0;
        r_per  <= '0;
        r_vld  <= 1'b0;
        r_err  <= '0;
      end else begin
        r_prev <= pulse_i[c];
        r_cnt  <= w_edge ? '0 : (w_sat ? r_cnt : r_cnt + C_ONE);
        r_per  <= w_edge ? w_p : r_per;
        r_vld  <= w_edge && w_en && (r_st != IDLE);
        r_err  <= clear_i[c] ? '0 : (w_loss && !(&r_err)) ? r_err + E_ONE : r_err;
      end
    end
    assign period_o[c*CNT_WIDTH +: CNT_WIDTH]  = r_per;
    assign period_vld_o[c]                     = r_vld;
    assign locked_o[c]                         = (r_st == LOCKED);
    assign err_cnt_o[c*ERR_WIDTH +: ERR_WIDTH] = r_err;
  end
endmodule

// File: tb/tb_pulse_period_monitor.sv
// tb_pulse_period_monitor: directed scoreboard bench for pulse_period_monitor
module tb_pulse_period_monitor;
  localparam int NC = 4;
  localparam int CW = 8;
  localparam int EW = 2;
  typedef struct {int ch; int p; bit lk;} exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [NC-1:0] pulse_i, clear_i, period_vld_o, locked_o;
  logic [NC*CW-1:0] expected_i, period_o;
  logic [NC*EW-1:0] err_cnt_o;
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  pulse_period_monitor #(.NUM_CH(NC), .CNT_WIDTH(CW), .LOCK_COUNT(4), .TOL(2), .ERR_WIDTH(EW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .pulse_i(pulse_i), .expected_i(expected_i), .clear_i(clear_i),
    .period_o(period_o), .period_vld_o(period_vld_o), .locked_o(locked_o), .err_cnt_o(err_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) if (period_vld_o[c]) begin
      chk("vld_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("vld_ch", c, e.ch);
        chk("period", 32'(period_o[c*CW +: CW]), e.p);
        chk("lock_at_vld", 32'(locked_o[c]), 32'(e.lk));
      end
    end
    chk("vld_missing", sb.size(), 0);
    sb.delete();
  endtask
  task automatic idle(input int n);
    repeat (n) cyc();
  endtask
  task automatic fire(input logic [NC-1:0] m, input logic [NC-1:0] vm, input int p, input bit lk);
    for (int c = 0; c < NC; c++) if (vm[c]) sb.push_back('{c, p, lk});
    pulse_i = m;
    cyc();
    pulse_i = '0;
  endtask
  task automatic pulse(input logic [NC-1:0] m, input logic [NC-1:0] vm, input int gap, input bit lk);
    idle(gap - 1);
    fire(m, vm, gap, lk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, period_o, 0);
    chk({tag, "_vld"}, 32'(period_vld_o), 0);
    chk({tag, "_locked"}, 32'(locked_o), 0);
    chk({tag, "_err"}, 32'(err_cnt_o), 0);
  endtask
  initial begin
    rst = 1'b1;
    pulse_i = '1;
    clear_i = '0;
    expected_i = {8'd0, 8'd10, 8'd10, 8'd10};
    idle(2);
    chk_zero("reset");
    rst = 1'b0;
    idle(3);
    chk("held_high_no_edge", period_o, 0);
    pulse_i = '0;
    pulse(4'b1001, 4'b0000, 5, 0);
    pulse(4'b1001, 4'b0001, 10, 0);
    pulse(4'b1001, 4'b0001, 10, 0);
    pulse(4'b1001, 4'b0001, 10, 0);
    chk("pre_lock", 32'(locked_o[0]), 0);
    pulse(4'b1001, 4'b0001, 10, 1);
    chk("lock_ch0", 32'(locked_o[0]), 1);
    chk("period_ch0", 32'(period_o[7:0]), 10);
    chk("disabled_period_ch3", 32'(period_o[31:24]), 10);
    chk("disabled_lock_ch3", 32'(locked_o[3]), 0);
    pulse(4'b0001, 4'b0001, 13, 0);
    chk("gap13_err", 32'(err_cnt_o[1:0]), 1);
    chk("gap13_unlock", 32'(locked_o[0]), 0);
    pulse(4'b0001, 4'b0001, 10, 0);
    pulse(4'b0001, 4'b0001, 10, 0);
    pulse(4'b0001, 4'b0001, 10, 0);
    pulse(4'b0001, 4'b0001, 10, 1);
    chk("relock", 32'(locked_o[0]), 1);
    idle(13);
    chk("before_timeout", 32'(locked_o[0]), 1);
    idle(1);
    chk("timeout_unlock", 32'(locked_o[0]), 0);
    chk("timeout_err", 32'(err_cnt_o[1:0]), 2);
    idle(300);
    chk("stopped_err_hold", 32'(err_cnt_o[1:0]), 2);
    fire(4'b0001, 4'b0001, 255, 0);
    pulse(4'b0001, 4'b0001, 10, 0);
    pulse(4'b0001, 4'b0001, 10, 0);
    pulse(4'b0001, 4'b0001, 10, 0);
    pulse(4'b0001, 4'b0001, 10, 1);
    pulse(4'b0001, 4'b0001, 7, 0);
    chk("err3", 32'(err_cnt_o[1:0]), 3);
    pulse(4'b0001, 4'b0001, 10, 0);
    pulse(4'b0001, 4'b0001, 10, 0);
    pulse(4'b0001, 4'b0001, 10, 0);
    pulse(4'b0001, 4'b0001, 10, 1);
    pulse(4'b0001, 4'b0001, 13, 0);
    chk("err_saturate", 32'(err_cnt_o[1:0]), 3);
    pulse(4'b0001, 4'b0001, 10, 0);
    pulse(4'b0001, 4'b0001, 10, 0);
    pulse(4'b0001, 4'b0001, 10, 0);
    pulse(4'b0001, 4'b0001, 10, 1);
    idle(6);
    clear_i = 4'b0001;
    fire(4'b0001, 4'b0001, 7, 0);
    clear_i = '0;
    chk("clear_wins", 32'(err_cnt_o[1:0]), 0);
    pulse(4'b0010, 4'b0000, 5, 0);
    pulse(4'b0010, 4'b0010, 8, 0);
    pulse(4'b0010, 4'b0010, 12, 0);
    pulse(4'b0010, 4'b0010, 8, 0);
    pulse(4'b0010, 4'b0010, 12, 1);
    chk("lock_8_12", 32'(locked_o[1]), 1);
    pulse(4'b0100, 4'b0000, 5, 0);
    pulse(4'b0100, 4'b0100, 10, 0);
    pulse(4'b0100, 4'b0100, 10, 0);
    pulse(4'b0100, 4'b0100, 10, 0);
    pulse(4'b0100, 4'b0100, 13, 0);
    pulse(4'b0100, 4'b0100, 10, 0);
    pulse(4'b0100, 4'b0100, 10, 0);
    pulse(4'b0100, 4'b0100, 10, 0);
    pulse(4'b0100, 4'b0100, 7, 0);
    chk("no_lock_7_13", 32'(locked_o[2]), 0);
    pulse(4'b0100, 4'b0100, 10, 0);
    pulse(4'b0100, 4'b0100, 10, 0);
    pulse(4'b0100, 4'b0100, 10, 0);
    pulse(4'b0100, 4'b0100, 10, 1);
    chk("lock_ch2", 32'(locked_o[2]), 1);
    chk("ch1_timeout_err", 32'(err_cnt_o[3:2]), 1);
    chk("ch0_err_indep", 32'(err_cnt_o[1:0]), 0);
    idle(4);
    rst = 1'b1;
    fire(4'b0100, 4'b0000, 0, 0);
    rst = 1'b0;
    chk_zero("mid_reset");
    cyc();
    chk_zero("post_reset");
    pulse(4'b0100, 4'b0000, 5, 0);
    pulse(4'b0100, 4'b0100, 10, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
